// File: rtl/stream_pkg.sv
// Width helpers shared by the AXI-stream style blocks.
package stream_pkg;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// Beat storage: one synchronous write port, one asynchronous read port.
module stream_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_fifo.sv
// Stream FIFO with full beat side-band; store-and-forward when
// STREAM_FIFO_PACKET_MODE_EN is defined.
module stream_fifo import stream_pkg::*; #(
  parameter int ID_WIDTH   = 1,
  parameter int DATA_WIDTH = 64,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1,
  parameter int DEPTH      = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ID_WIDTH-1:0]               s_t_id,
  input  logic [DEST_WIDTH-1:0]             s_t_dest,
  input  logic [DATA_WIDTH-1:0]             s_t_data,
  input  logic [strb_width(DATA_WIDTH)-1:0] s_t_strb,
  input  logic [strb_width(DATA_WIDTH)-1:0] s_t_keep,
  input  logic                              s_t_last,
  input  logic [USER_WIDTH-1:0]             s_t_user,
  input  logic                              s_t_valid,
  output logic                              s_t_ready,
  output logic [ID_WIDTH-1:0]               m_t_id,
  output logic [DEST_WIDTH-1:0]             m_t_dest,
  output logic [DATA_WIDTH-1:0]             m_t_data,
  output logic [strb_width(DATA_WIDTH)-1:0] m_t_strb,
  output logic [strb_width(DATA_WIDTH)-1:0] m_t_keep,
  output logic                              m_t_last,
  output logic [USER_WIDTH-1:0]             m_t_user,
  output logic                              m_t_valid,
  input  logic                              m_t_ready,
  output logic [count_width(DEPTH)-1:0]     level,
  output logic                              full,
  output logic                              empty
);

  localparam int SW = strb_width(DATA_WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam int WW = ID_WIDTH + DEST_WIDTH + DATA_WIDTH + 2 * SW + 1 + USER_WIDTH;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

  if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
    $fatal(1, "stream_fifo: DATA_WIDTH must be a multiple of 8");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "stream_fifo: DEPTH must be a power of two >= 2");
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] level_q, level_d;
  logic [WW-1:0] wr_word, rd_word;
  logic          push, pop, full_q, empty_q;

  assign full_q  = (level_q == FULL_LVL);
  assign empty_q = (level_q == '0);

  // Ready depends only on stored state: no pass-through from m_t_ready.
  assign s_t_ready = !rst && !full_q;
  assign push      = s_t_valid && s_t_ready;
  assign pop       = m_t_valid && m_t_ready;

  assign level = rst ? '0 : level_q;
  assign full  = !rst && full_q;
  assign empty = rst || empty_q;

`ifdef STREAM_FIFO_PACKET_MODE_EN
  logic [CW-1:0] pkt_q, pkt_d;

  // Head is released once a whole packet is held, or when full so a
  // packet larger than the FIFO cannot deadlock it.
  assign m_t_valid = !rst && !empty_q && ((pkt_q != '0) || full_q);

  always_comb begin
    pkt_d = pkt_q + CW'(push && s_t_last) - CW'(pop && m_t_last);
  end

  always_ff @(posedge clk) begin
    if (rst) pkt_q <= '0;
    else     pkt_q <= pkt_d;
  end
`else
  assign m_t_valid = !rst && !empty_q;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign wr_word = {s_t_id, s_t_dest, s_t_data, s_t_strb, s_t_keep, s_t_last, s_t_user};
  assign {m_t_id, m_t_dest, m_t_data, m_t_strb, m_t_keep, m_t_last, m_t_user} = rd_word;

  stream_fifo_ram #(
    .WIDTH (WW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_word),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_word)
  );

endmodule

// File: tb/tb_stream_fifo.sv
// Directed and random stimulus for stream_fifo against a queue-based model.
module tb_stream_fifo;

`ifdef STREAM_FIFO_PACKET_MODE_EN
  localparam int DEPTH = 8;
`else
  localparam int DEPTH = 4;
`endif
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [1:0]  id;
    logic [1:0]  dest;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  keep;
    logic        last;
    logic [2:0]  user;
  } beat_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] s_t_id = '0, s_t_dest = '0, m_t_id, m_t_dest;
  logic [31:0] s_t_data = '0, m_t_data;
  logic [3:0] s_t_strb = '0, s_t_keep = '0, m_t_strb, m_t_keep;
  logic s_t_last = 1'b0, s_t_valid = 1'b0, s_t_ready, m_t_last, m_t_valid, m_t_ready = 1'b0;
  logic [2:0] s_t_user = '0, m_t_user;
  logic [CW-1:0] level;
  logic full, empty;

  int n_tests = 0, n_fail = 0;
  beat_t q[$];

  always #5 clk = ~clk;

  stream_fifo #(
    .ID_WIDTH(2), .DATA_WIDTH(32), .DEST_WIDTH(2), .USER_WIDTH(3), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_t_id(s_t_id), .s_t_dest(s_t_dest), .s_t_data(s_t_data), .s_t_strb(s_t_strb),
    .s_t_keep(s_t_keep), .s_t_last(s_t_last), .s_t_user(s_t_user),
    .s_t_valid(s_t_valid), .s_t_ready(s_t_ready),
    .m_t_id(m_t_id), .m_t_dest(m_t_dest), .m_t_data(m_t_data), .m_t_strb(m_t_strb),
    .m_t_keep(m_t_keep), .m_t_last(m_t_last), .m_t_user(m_t_user),
    .m_t_valid(m_t_valid), .m_t_ready(m_t_ready),
    .level(level), .full(full), .empty(empty)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] data, input logic last);
    beat_t b;
    b.id = 2'($urandom); b.dest = 2'($urandom); b.data = data;
    b.strb = 4'($urandom); b.keep = 4'($urandom); b.last = last; b.user = 3'($urandom);
    return b;
  endfunction

  // Head may leave when anything is stored (stream) or when a whole packet
  // is stored / the FIFO is full (store-and-forward).
  function automatic bit model_valid();
    int lasts = 0;
    foreach (q[i]) if (q[i].last) lasts++;
`ifdef STREAM_FIFO_PACKET_MODE_EN
    return q.size() > 0 && (lasts > 0 || q.size() == DEPTH);
`else
    return q.size() > 0;
`endif
  endfunction

  // One cycle: drive at negedge, check settled outputs, model the edge.
  task automatic step(input logic r, input logic sv, input logic mr, input beat_t b);
    bit ev, er, do_push, do_pop;
    rst = r; s_t_valid = sv; m_t_ready = mr;
    {s_t_id, s_t_dest, s_t_data, s_t_strb, s_t_keep, s_t_last, s_t_user} = b;
    #1;
    ev = !r && model_valid();
    er = !r && q.size() < DEPTH;
    chk("s_t_ready", 64'(s_t_ready), 64'(er));
    chk("m_t_valid", 64'(m_t_valid), 64'(ev));
    chk("level", 64'(level), r ? 64'd0 : 64'(q.size()));
    chk("full", 64'(full), 64'(!r && q.size() == DEPTH));
    chk("empty", 64'(empty), 64'(r || q.size() == 0));
    if (ev) begin
      chk("m_t_data", 64'(m_t_data), 64'(q[0].data));
      chk("m_side", 64'({m_t_id, m_t_dest, m_t_strb, m_t_keep, m_t_last, m_t_user}),
          64'({q[0].id, q[0].dest, q[0].strb, q[0].keep, q[0].last, q[0].user}));
    end
    do_push = sv && er;
    do_pop  = ev && mr;
    @(posedge clk);
    if (r) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(b);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2 && q.size() > 0; i++) step(0, 0, 1, mk(0, 0));
  endtask

  initial begin
    @(negedge clk);
    step(1, 0, 0, mk(0, 0));
    step(1, 1, 1, mk(32'h5, 1));

    // Fill with 0x11..0x44 while stalled, then drain in order.
    for (int i = 0; i < 4; i++) step(0, 1, 0, mk(32'h11 * (i + 1), i == 3));
`ifndef STREAM_FIFO_PACKET_MODE_EN
    chk("fill_level", 64'(level), 64'd4);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_ready", 64'(s_t_ready), 64'd0);
`endif
    for (int i = 0; i < 4; i++) step(0, 0, 1, mk(0, 0));
    chk("drain_empty", 64'(empty), 64'd1);

    // Single beat latency: visible the cycle after push, gone the cycle after pop.
    step(0, 1, 1, mk(32'hAA, 1));
    step(0, 0, 1, mk(0, 0));
    step(0, 0, 1, mk(0, 0));
    chk("lat_level", 64'(level), 64'd0);

    // Steady-state push+pop at level 2; pointers wrap repeatedly.
    step(0, 1, 0, mk(32'($urandom), 1));
    step(0, 1, 0, mk(32'($urandom), 1));
    for (int i = 0; i < 20; i++) step(0, 1, 1, mk(32'($urandom), 1));
    chk("stream_level", 64'(level), 64'd2);
    drain();

    // Reset mid-packet discards everything.
    for (int i = 0; i < 3; i++) step(0, 1, 0, mk(32'hC0 + i, 0));
    step(1, 1, 1, mk(32'hDEAD, 0));
    rst = 1'b0; s_t_valid = 1'b0; m_t_ready = 1'b1;
    #1;
    chk("post_rst_ready", 64'(s_t_ready), 64'd1);
    chk("post_rst_valid", 64'(m_t_valid), 64'd0);
    chk("post_rst_level", 64'(level), 64'd0);
    step(0, 1, 1, mk(32'hE1, 1));
    step(0, 0, 1, mk(0, 0));
    step(0, 0, 1, mk(0, 0));

`ifdef STREAM_FIFO_PACKET_MODE_EN
    step(1, 0, 0, mk(0, 0));
    for (int i = 0; i < 3; i++) step(0, 1, 0, mk(32'hB0 + i, i == 2));
    chk("pkt_release", 64'(m_t_valid), 64'd1);
    drain();
    step(1, 0, 0, mk(0, 0));
    for (int i = 0; i < 8; i++) step(0, 1, 0, mk(32'hF0 + i, 0));
    chk("pkt_full_valid", 64'(m_t_valid), 64'd1);
    drain();
    step(1, 0, 0, mk(0, 0));
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, 1'($urandom), 1'($urandom),
           mk(32'($urandom), $urandom_range(0, 2) == 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
